// File: rtl/mux_line_scheduler_if.sv
// Frame handoff channel between the mux line scheduler and the UART readout path.
// The source presents a finished frame (frame_valid, frame_chan) and holds it until the sink
// raises frame_ready; a transfer happens on any cycle where both are high.
//   frame_valid  source -> sink  frame ready for readout
//   frame_chan   source -> sink  mux channel index of the presented frame
//   frame_ready  sink -> source  readout accepts the frame
interface mux_line_scheduler_if #(
    parameter int MUX_LINES = 2
) ();
    logic                 frame_valid;
    logic [MUX_LINES-1:0] frame_chan;
    logic                 frame_ready;

    modport master (
        output frame_valid,
        output frame_chan,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_chan,
        output frame_ready
    );
endinterface

// File: rtl/mux_line_scheduler.sv
// Mux line scheduler: sweeps the enabled mux channels, and for each one selects it, waits a
// settle time, gates the correlator accumulators for an integration window, then hands the
// frame to the readout path over a valid/ready handshake.
// Ports:
//   clki           system clock
//   reset_n        synchronous reset, active low
//   enable         run request
//   chan_mask      per-channel enable, bit i enables mux channel i
//   settle_cycles  settle delay after each mux switch (cycles)
//   window_len     integration length in cycles (0 behaves as 1)
//   mux_addr       mux channel select
//   mux_oe         mux output enable
//   acc_clear      one-cycle accumulator clear at the start of each channel
//   acc_en         accumulator gate
//   frame          frame handoff (master side: frame_valid, frame_chan out; frame_ready in)
//   sweep_done     one-cycle pulse at the end of each sweep
//   sweep_count    completed sweeps, wrapping
//   busy           high whenever the scheduler is not idle
module mux_line_scheduler #(
    parameter  int MUX_LINES    = 2,
    parameter  int SETTLE_WIDTH = 8,
    parameter  int WINDOW_WIDTH = 16,
    parameter  int SWEEP_WIDTH  = 16,
    localparam int MUX_CHANNELS = 2 ** MUX_LINES
) (
    input  logic                    clki,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [MUX_CHANNELS-1:0] chan_mask,
    input  logic [SETTLE_WIDTH-1:0] settle_cycles,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    output logic [MUX_LINES-1:0]    mux_addr,
    output logic                    mux_oe,
    output logic                    acc_clear,
    output logic                    acc_en,
    mux_line_scheduler_if.master    frame,
    output logic                    sweep_done,
    output logic [SWEEP_WIDTH-1:0]  sweep_count,
    output logic                    busy
);

    // One extra bit so that stepping past the last channel reads as "none found".
    localparam int PTR_W = MUX_LINES + 1;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSettle,
        StIntegrate,
        StDump
    } state_e;

    state_e                  state;
    logic [MUX_CHANNELS-1:0] mask_s;
    logic [SETTLE_WIDTH-1:0] settle_s;
    logic [WINDOW_WIDTH-1:0] window_s;
    logic [SETTLE_WIDTH-1:0] settle_cnt;
    logic [WINDOW_WIDTH-1:0] window_cnt;
    logic [PTR_W-1:0]        ptr;
    logic                    frame_valid_q;
    logic [MUX_LINES-1:0]    frame_chan_q;

    logic                    start_ok;
    logic [WINDOW_WIDTH-1:0] window_clamped;
    logic                    found;
    logic [MUX_LINES-1:0]    found_idx;

    assign start_ok       = enable && (chan_mask != '0);
    assign window_clamped = (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;

    assign frame.frame_valid = frame_valid_q;
    assign frame.frame_chan  = frame_chan_q;

    // Lowest set bit of the shadow mask at or above ptr; scanning downwards lets the lowest
    // qualifying index win.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = MUX_CHANNELS - 1; i >= 0; i--) begin
            if (mask_s[i] && (PTR_W'(i) >= ptr)) begin
                found     = 1'b1;
                found_idx = MUX_LINES'(i);
            end
        end
    end

    always_ff @(posedge clki) begin
        if (!reset_n) begin
            state         <= StIdle;
            mask_s        <= '0;
            settle_s      <= '0;
            window_s      <= '0;
            settle_cnt    <= '0;
            window_cnt    <= '0;
            ptr           <= '0;
            mux_addr      <= '0;
            mux_oe        <= 1'b0;
            acc_clear     <= 1'b0;
            acc_en        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_chan_q  <= '0;
            sweep_done    <= 1'b0;
            sweep_count   <= '0;
            busy          <= 1'b0;
        end else begin
            acc_clear  <= 1'b0;
            sweep_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start_ok) begin
                        mask_s   <= chan_mask;
                        settle_s <= settle_cycles;
                        window_s <= window_clamped;
                        ptr      <= '0;
                        busy     <= 1'b1;
                        state    <= StSelect;
                    end
                end
                StSelect: begin
                    // A dropped enable ends the sweep here even if masked channels remain.
                    if (enable && found) begin
                        mux_addr   <= found_idx;
                        mux_oe     <= 1'b1;
                        acc_clear  <= 1'b1;
                        settle_cnt <= settle_s;
                        state      <= StSettle;
                    end else begin
                        sweep_done  <= 1'b1;
                        sweep_count <= sweep_count + SWEEP_WIDTH'(1);
                        if (start_ok) begin
                            // Continuous sweeping: mux_oe stays up across the boundary.
                            mask_s   <= chan_mask;
                            settle_s <= settle_cycles;
                            window_s <= window_clamped;
                            ptr      <= '0;
                        end else begin
                            mux_oe <= 1'b0;
                            busy   <= 1'b0;
                            state  <= StIdle;
                        end
                    end
                end
                StSettle: begin
                    if (settle_cnt == '0) begin
                        window_cnt <= window_s;
                        acc_en     <= 1'b1;
                        state      <= StIntegrate;
                    end else begin
                        settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
                    end
                end
                StIntegrate: begin
                    if (window_cnt == WINDOW_WIDTH'(1)) begin
                        acc_en        <= 1'b0;
                        frame_valid_q <= 1'b1;
                        frame_chan_q  <= mux_addr;
                        state         <= StDump;
                    end else begin
                        window_cnt <= window_cnt - WINDOW_WIDTH'(1);
                    end
                end
                StDump: begin
                    if (frame.frame_ready) begin
                        frame_valid_q <= 1'b0;
                        ptr           <= PTR_W'(mux_addr) + PTR_W'(1);
                        state         <= StSelect;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_line_scheduler.sv
// Self-checking bench for mux_line_scheduler: a per-cycle reference model built from the sweep
// rules (queue of channels, elapsed-cycle arithmetic per channel) plus directed scenarios with
// hand-computed expectations on frame order, settle/window lengths and sweep counts.
module tb_mux_line_scheduler;

    localparam int ML = 2;

    logic        clki = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  chan_mask;
    logic [7:0]  settle_cycles;
    logic [15:0] window_len;
    logic [1:0]  mux_addr;
    logic        mux_oe;
    logic        acc_clear;
    logic        acc_en;
    logic        sweep_done;
    logic [15:0] sweep_count;
    logic        busy;

    mux_line_scheduler_if #(.MUX_LINES(ML)) fb ();

    mux_line_scheduler #(
        .MUX_LINES   (ML),
        .SETTLE_WIDTH(8),
        .WINDOW_WIDTH(16),
        .SWEEP_WIDTH (16)
    ) dut (
        .clki         (clki),
        .reset_n      (reset_n),
        .enable       (enable),
        .chan_mask    (chan_mask),
        .settle_cycles(settle_cycles),
        .window_len   (window_len),
        .mux_addr     (mux_addr),
        .mux_oe       (mux_oe),
        .acc_clear    (acc_clear),
        .acc_en       (acc_en),
        .frame        (fb),
        .sweep_done   (sweep_done),
        .sweep_count  (sweep_count),
        .busy         (busy)
    );

    always #5 clki = ~clki;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (updated on each rising edge) ----------------
    bit m_busy, m_sel, m_oe, m_clr, m_done, chk_on;
    int m_addr, m_t, m_s, m_w, m_count;
    int m_q[$];

    task automatic model_latch();
        m_q.delete();
        for (int i = 0; i < 4; i++) if (chan_mask[i]) m_q.push_back(i);
        m_s = int'(settle_cycles);
        m_w = (window_len == 16'd0) ? 1 : int'(window_len);
    endtask

    initial begin
        m_busy = 0; m_sel = 0; m_oe = 0; m_clr = 0; m_done = 0; chk_on = 0;
        m_addr = 0; m_t = 0; m_s = 0; m_w = 1; m_count = 0;
        forever begin
            @(posedge clki);
            m_clr  = 0;
            m_done = 0;
            if (!reset_n) begin
                m_busy = 0; m_sel = 0; m_oe = 0; m_addr = 0; m_t = 0; m_count = 0;
                m_q.delete();
                chk_on = 1;
            end else if (!m_busy) begin
                if (enable && chan_mask != 4'd0) begin
                    model_latch();
                    m_busy = 1;
                    m_sel  = 1;
                end
            end else if (m_sel) begin
                if (enable && m_q.size() > 0) begin
                    m_addr = m_q.pop_front();
                    m_oe   = 1;
                    m_clr  = 1;
                    m_sel  = 0;
                    m_t    = 0;
                end else begin
                    m_done  = 1;
                    m_count = (m_count + 1) % 65536;
                    if (enable && chan_mask != 4'd0) model_latch();
                    else begin
                        m_oe   = 0;
                        m_busy = 0;
                    end
                end
            end else if (m_t >= m_s + 1 + m_w) begin
                // Frame presented: leave once the readout takes it.
                if (fb.frame_ready) m_sel = 1;
            end else begin
                m_t++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [25:0] cmp_exp, cmp_act;
    bit          e_en, e_v;

    initial begin
        forever begin
            @(negedge clki);
            if (chk_on) begin
                e_en = m_busy && !m_sel && (m_t >= m_s + 1) && (m_t <= m_s + m_w);
                e_v  = m_busy && !m_sel && (m_t >= m_s + 1 + m_w);
                cmp_exp = {m_busy, m_oe, m_oe ? 2'(m_addr) : 2'd0, m_clr, e_en, e_v,
                           e_v ? 2'(m_addr) : 2'd0, m_done, 16'(m_count)};
                cmp_act = {busy, mux_oe, m_oe ? mux_addr : 2'd0, acc_clear, acc_en,
                           fb.frame_valid, e_v ? fb.frame_chan : 2'd0, sweep_done, sweep_count};
                check("cycle", 64'(cmp_act), 64'(cmp_exp));
            end
        end
    end

    // ---------------- monitor: frame log and phase lengths ----------------
    logic [31:0] frame_sig, en_sig, settle_sig;
    int          frame_n, done_n, scnt, ecnt;
    bit          in_settle;

    initial begin
        frame_sig = 0; en_sig = 0; settle_sig = 0;
        frame_n = 0; done_n = 0; scnt = 0; ecnt = 0; in_settle = 0;
        forever begin
            @(negedge clki);
            #3;
            if (reset_n !== 1'b1) begin
                in_settle = 0; scnt = 0; ecnt = 0;
            end else begin
                if (acc_clear) begin in_settle = 1; scnt = 0; ecnt = 0; end
                if (in_settle && !acc_en) scnt++;
                if (in_settle && acc_en) begin
                    in_settle  = 0;
                    settle_sig = {settle_sig[27:0], 4'(scnt)};
                end
                if (acc_en) ecnt++;
                if (fb.frame_valid && fb.frame_ready) begin
                    frame_sig = {frame_sig[27:0], 4'(fb.frame_chan)};
                    en_sig    = {en_sig[27:0], 4'(ecnt)};
                    frame_n++;
                end
                if (sweep_done) done_n++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clki);
        #1;
    endtask

    task automatic clear_logs();
        frame_sig = 0; en_sig = 0; settle_sig = 0; frame_n = 0; done_n = 0;
    endtask

    // kind: 0 sweep_done, 1 idle, 2 acc_en on channel arg, 3 frame_valid, 4 mid-settle,
    // 5 acc_clear
    task automatic wait_for(input string name, input int kind, input int arg, input int limit);
        bit hit;
        hit = 0;
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            case (kind)
                0: hit = sweep_done;
                1: hit = !busy;
                2: hit = acc_en && (int'(mux_addr) == arg);
                3: hit = fb.frame_valid;
                4: hit = mux_oe && busy && !acc_clear && !acc_en && !fb.frame_valid;
                default: hit = acc_clear;
            endcase
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL timeout_%s: condition not seen in %0d cycles, required within %0d",
                     name, limit, limit);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, mux_oe, mux_addr, acc_clear, acc_en, fb.frame_valid, fb.frame_chan,
                    sweep_done, sweep_count});
    endfunction

    initial begin
        reset_n = 0; enable = 0; chan_mask = 4'hF; settle_cycles = 8'd2; window_len = 16'd5;
        fb.frame_ready = 1;
        repeat (3) step();
        check("reset_outputs", all_outs(), 64'd0);
        reset_n = 1;

        // All-ones mask, settle 2, window 5.
        clear_logs();
        enable = 1;
        wait_for("sweep1", 0, 0, 200);
        check("t1_frame_n", 64'(frame_n), 64'd4);
        check("t1_order", 64'(frame_sig), 64'h0123);
        check("t1_acc_en_len", 64'(en_sig), 64'h5555);
        check("t1_settle_len", 64'(settle_sig), 64'h3333);
        check("t1_sweep_count", 64'(sweep_count), 64'd1);
        enable = 0;
        wait_for("t1_idle", 1, 0, 100);
        check("t1_sweep_count2", 64'(sweep_count), 64'd2);
        check("t1_oe_off", 64'(mux_oe), 64'd0);

        // Sparse mask, zero settle, zero window clamped to 1.
        clear_logs();
        chan_mask = 4'b1010; settle_cycles = 8'd0; window_len = 16'd0;
        enable = 1;
        wait_for("sparse", 0, 0, 100);
        check("t2_frame_n", 64'(frame_n), 64'd2);
        check("t2_order", 64'(frame_sig), 64'h13);
        check("t2_settle_len", 64'(settle_sig), 64'h11);
        check("t2_acc_en_len", 64'(en_sig), 64'h11);
        check("t2_sweep_count", 64'(sweep_count), 64'd3);
        enable = 0;
        wait_for("t2_idle", 1, 0, 100);
        check("t2_sweep_count2", 64'(sweep_count), 64'd4);

        // Enable dropped during the integration of channel 1.
        clear_logs();
        chan_mask = 4'hF; settle_cycles = 8'd1; window_len = 16'd3;
        enable = 1;
        wait_for("drop_ch1", 2, 1, 100);
        enable = 0;
        wait_for("drop_idle", 1, 0, 100);
        check("drop_order", 64'(frame_sig), 64'h01);
        check("drop_frame_n", 64'(frame_n), 64'd2);
        check("drop_done_n", 64'(done_n), 64'd1);
        check("drop_sweep_count", 64'(sweep_count), 64'd5);
        check("drop_oe_busy", 64'({mux_oe, busy}), 64'd0);

        // Backpressure on channel 2.
        clear_logs();
        settle_cycles = 8'd1; window_len = 16'd2;
        enable = 1;
        wait_for("bp_ch2", 2, 2, 100);
        fb.frame_ready = 0;
        wait_for("bp_valid", 3, 0, 20);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            check("bp_hold", 64'({fb.frame_valid, fb.frame_chan, acc_en}), 64'b1_10_0);
        end
        fb.frame_ready = 1;
        step();
        check("bp_advance", 64'({fb.frame_valid, busy}), 64'b01);
        enable = 0;
        wait_for("bp_idle", 1, 0, 100);
        check("bp_order", 64'(frame_sig), 64'h012);
        check("bp_sweep_count", 64'(sweep_count), 64'd6);

        // Mask change mid-sweep only takes effect at the next latch.
        clear_logs();
        chan_mask = 4'hF;
        enable = 1;
        wait_for("mask_ch1", 2, 1, 100);
        chan_mask = 4'b0001;
        wait_for("mask_sweep1", 0, 0, 100);
        check("mask_order1", 64'(frame_sig), 64'h0123);
        wait_for("mask_sweep2", 0, 0, 100);
        check("mask_order2", 64'(frame_sig), 64'h1230);
        check("mask_frame_n", 64'(frame_n), 64'd5);
        enable = 0;
        wait_for("mask_idle", 1, 0, 100);
        check("mask_sweep_count", 64'(sweep_count), 64'd9);

        // Reset during settle, then restart from channel 0.
        clear_logs();
        chan_mask = 4'hF; settle_cycles = 8'd4; window_len = 16'd3;
        enable = 1;
        wait_for("rst_settle", 4, 0, 50);
        reset_n = 0;
        step();
        check("mid_reset_outputs", all_outs(), 64'd0);
        reset_n = 1;
        wait_for("rst_restart", 5, 0, 50);
        check("rst_restart_chan", 64'(mux_addr), 64'd0);
        enable = 0;
        wait_for("rst_idle", 1, 0, 100);
        check("rst_frames", 64'({frame_sig[7:0], 8'(frame_n)}), 64'h0001);
        check("rst_sweep_count", 64'(sweep_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_line_scheduler.md
Name: mux_line_scheduler

Overview:
- Sequences the external analog/line multiplexer driven from the correlator top level (mux address plus output enable).
- For each enabled channel in a sweep, it selects the channel, waits a programmable settle time, and gates the correlator accumulators for a programmable integration window.
- It then hands the finished frame to the UART readout path over a valid/ready handshake.
- Sits between the command/register block (mask, timings, enable) and the correlator/accumulator datapath inside main.

Parameters:
- MUX_LINES, 2, width of the mux address; number of channels is MUX_CHANNELS = 2**MUX_LINES.
- SETTLE_WIDTH, 8, width of the settle-time register (cycles).
- WINDOW_WIDTH, 16, width of the integration-window register (cycles).
- SWEEP_WIDTH, 16, width of the completed-sweep counter.

Ports:
- clki  in  1  system clock (PLL output).
- reset_n  in  1  synchronous reset, active low.
- enable  in  1  run request from the register block.
- chan_mask  in  MUX_CHANNELS  per-channel enable; bit i enables mux channel i.
- settle_cycles  in  SETTLE_WIDTH  settle delay after each mux switch.
- window_len  in  WINDOW_WIDTH  integration length in cycles.
- mux_addr  out  MUX_LINES  mux channel select.
- mux_oe  out  1  mux output enable.
- acc_clear  out  1  one-cycle accumulator clear pulse.
- acc_en  out  1  accumulator gate.
- frame_valid  out  1  frame ready for readout.
- frame_chan  out  MUX_LINES  channel index of the presented frame.
- frame_ready  in  1  readout accepts the frame.
- sweep_done  out  1  one-cycle pulse at end of each sweep.
- sweep_count  out  SWEEP_WIDTH  completed sweeps; wraps modulo 2**SWEEP_WIDTH.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n=0 at a clki edge): state=IDLE.
  - All outputs are 0: mux_addr, mux_oe, acc_clear, acc_en, frame_valid, frame_chan, sweep_done, sweep_count, busy.
  - Internal pointer and counters are cleared.
  - Reset mid-operation aborts immediately; a pending frame is dropped and no sweep_done is issued.
- The state machine has five states: IDLE, SELECT, SETTLE, INTEGRATE, DUMP.
- IDLE:
  - When enable=1 and chan_mask!=0, latch the shadow registers mask_s, settle_s and window_s.
  - window_s = max(window_len, 1).
  - Set ptr=0 and go to SELECT.
  - If enable=1 and chan_mask==0, stay in IDLE.
- SELECT (exactly one cycle), lowest set bit of mask_s at index >= ptr:
  - If found (chan): next cycle mux_addr=chan, mux_oe=1, acc_clear=1 (for that one cycle only). Load the settle counter with settle_s and go to SETTLE.
  - If none: pulse sweep_done for one cycle and increment sweep_count.
    - If enable=1 and chan_mask!=0: re-latch the shadow registers, set ptr=0 and stay in SELECT.
    - Otherwise: mux_oe=0 and go to IDLE.
- SETTLE:
  - Lasts settle_s+1 cycles; settle_s=0 gives 1 cycle.
  - acc_en=0 throughout.
  - Then go to INTEGRATE with the window counter set to window_s.
- INTEGRATE:
  - acc_en=1 for exactly window_s consecutive cycles.
  - mux_addr is stable throughout.
  - Then acc_en=0 and go to DUMP.
- DUMP:
  - frame_valid=1 and frame_chan=chan, both held stable until frame_ready=1.
  - The transfer occurs on the cycle with frame_valid && frame_ready.
  - The next cycle: frame_valid=0, ptr=chan+1, go to SELECT.
  - frame_ready while frame_valid=0 is ignored.
  - No timeout: DUMP waits indefinitely.
- Pointer wrap: when chan is MUX_CHANNELS-1, ptr=chan+1 overflows. This is treated as "none found" (use a MUX_LINES+1-bit pointer), so the sweep ends.
- Changes to chan_mask, settle_cycles or window_len mid-sweep have no effect until the next shadow latch.
- enable deasserted mid-sweep:
  - The current channel completes through DUMP (no partial frames).
  - The next SELECT finishes the sweep: sweep_done pulses and sweep_count increments, even though the remaining masked channels are skipped.
  - Then IDLE.
- busy=0 only in IDLE.
- mux_oe stays 1 across back-to-back channels within and between continuous sweeps.

Test Plan:
- Reset and all-ones mask:
  - Stimulus: reset, then mask=4'b1111, settle=2, window=5, enable=1, frame_ready tied 1.
  - Required: frames for channels 0,1,2,3 in order. Each has acc_clear 1 cycle, 3 settle cycles, acc_en high 5 cycles, frame_valid 1 cycle. sweep_done pulses after chan 3; sweep_count=1.
- Sparse mask:
  - Stimulus: mask=4'b1010, settle=0, window=0.
  - Required: only chans 1 and 3 are visited. Settle is 1 cycle and acc_en is 1 cycle (window 0 is clamped to 1).
- Backpressure:
  - Stimulus: frame_ready held 0 for 10 cycles in DUMP of chan 2.
  - Required: frame_valid=1 and frame_chan=2 stable for all 10 cycles; acc_en=0; advance occurs exactly 1 cycle after frame_ready rises.
- Mid-sweep changes:
  - Stimulus: mask changed to 4'b0001 during chan 1 of a 4'b1111 sweep.
  - Required: chans 2 and 3 are still visited. The next sweep visits only chan 0.
- enable drop:
  - Stimulus: enable dropped during INTEGRATE of chan 1.
  - Required: chan 1 frame completes; sweep_done pulses; sweep_count increments; mux_oe=0; busy=0. No frame for chans 2 and 3.
- Mid-operation reset:
  - Stimulus: reset_n=0 in SETTLE.
  - Required: next cycle all outputs are 0, sweep_count=0, state=IDLE. A restart then begins at chan 0.
